alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single 32-bit ALU between two requesters (port 0: main decode/execute path; port 1: auxiliary address/compare engine) with round-robin arbitration and valid/ready handshakes. Latches the winning operands, drives the ALU for one cycle, and captures result and Z flag into a response register. Owns the architectural Z-flag register, updating it only for flag-setting ALU ops. Sits between the requesters and the ALU instance in the ARM datapath.

## Interface
- WIDTH, 32, operand/result width; must match the ALU.
- CNT_W, 16, width of the completed-operation counter.

- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid[1:0]  in  2  per-port request valid
- req_ready[1:0]  out  2  per-port accept (combinational from state and grant)
- req0_a, req0_b / req1_a, req1_b  in  WIDTH each  operands A/B per port
- req0_op, req1_op  in  3 each  ALU control code per port
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  1  port that issued the response
- rsp_result  out  WIDTH  captured ALU result
- rsp_flag  out  1  Z-flag value after this op
- alu_src_a, alu_src_b  out  WIDTH  to ALU SrcA/SrcB
- alu_control  out  3  to ALU control
- alu_result  in  WIDTH  from ALU result
- alu_flags  in  1  from ALU flag
- z_flag  out  1  architectural Z register
- ops_done  out  CNT_W  completed responses, wraps at 2^CNT_W

## Operation
- States: IDLE, EXEC, RESP. Reset -> IDLE.
- IDLE: grant = sole valid port; if both valid, port != last_grant. req_ready[grant]=1 only in IDLE with req_valid[grant]=1; all other ready bits 0. On handshake: latch a, b, op, id; last_grant<=grant; -> EXEC.
- EXEC: alu_src_a/b/alu_control driven from latches (held in every state). At end of cycle: rsp_result<=alu_result, rsp_id<=id; -> RESP.
- Op codes: 000 add, 001 sub, 010 pass B (no flag); 100 add, 101 sub, 110 pass B, 011 sub (flag-setting). Flag-setting: z_flag<=alu_flags in EXEC. Non-flag: z_flag holds. rsp_flag = z_flag value after the EXEC update.
- Op 111 (undefined): not sent to ALU; rsp_result<=0, z_flag<=1, rsp_flag=1. Handshake and counter unaffected otherwise.
- RESP: rsp_valid=1 and rsp_result/rsp_flag/rsp_id stable until rsp_ready=1; on handshake ops_done<=ops_done+1 (mod 2^CNT_W), -> IDLE. No request accepted in RESP, even if rsp_ready=1.
- Requesters must hold valid and operands stable until ready; dropping valid before ready is legal and simply withdraws the request.
- Arithmetic is modulo 2^WIDTH; no carry/overflow output.

## Timing
- Reset (async, immediate): state=IDLE, req_ready=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flag=0, z_flag=0, ops_done=0, alu_src_a/b=0, alu_control=000, last_grant=1 (port 0 wins the first tie).
- Latency: request handshake at edge N -> EXEC in cycle N+1 -> rsp_valid in cycle N+2. Minimum 3 cycles per operation (IDLE, EXEC, RESP with rsp_ready=1).
- Back-pressure: rsp_ready low holds RESP indefinitely; req_ready stays 0 throughout.
- Reset mid-EXEC or mid-RESP: transaction discarded, no response issued, counter not incremented.
- ops_done at 2^CNT_W-1 wraps to 0 on next completion.
- Simultaneous valids with last_grant=0: port 1 granted; port 0 granted on next IDLE if still valid (no starvation).

## Test plan
- Single op: port 0, a=5, b=3, op=000 -> rsp_valid 2 cycles after accept, rsp_result=8, rsp_id=0, z_flag unchanged (0), ops_done=1.
- Flag update: port 1, a=7, b=7, op=101 -> rsp_result=0, rsp_flag=1, z_flag=1; then op=000 a=1 b=2 -> result 3, rsp_flag stays 1.
- Round-robin: both ports valid continuously for 4 ops -> grant order 0,1,0,1; rsp_id matches; ops_done=4.
- Back-pressure: rsp_ready held low 5 cycles -> rsp_valid and rsp_result stable, req_ready[1:0]=00 throughout; completes when rsp_ready rises.
- Undefined op 111 on port 0 -> rsp_result=0, rsp_flag=1, z_flag=1; ALU alu_control never shows 111.
- Reset asserted in EXEC and in RESP -> all outputs at reset values immediately; ops_done=0; next request from port 0 served first.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters.
// Latches the winning operands, runs the ALU for one cycle, and holds the response until it is consumed.
module alu_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req0_op,
  input  logic [2:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_flag,
  output logic [WIDTH-1:0] alu_src_a,
  output logic [WIDTH-1:0] alu_src_b,
  output logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_flags,
  output logic             z_flag,
  output logic [CNT_W-1:0] ops_done
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  logic             last_grant;
  logic             grant;
  logic             id_q;
  logic             undef_q;
  logic             setflag_q;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [2:0]       sel_op;

  // Contested cycles go to the port that did not win last time.
  always_comb begin
    grant = 1'b0;
    if (req_valid == 2'b10)
      grant = 1'b1;
    else if (req_valid == 2'b11)
      grant = ~last_grant;
    sel_a  = grant ? req1_a  : req0_a;
    sel_b  = grant ? req1_b  : req0_b;
    sel_op = grant ? req1_op : req0_op;
    req_ready = '0;
    if (state == IDLE && !reset && req_valid[grant])
      req_ready[grant] = 1'b1;
  end

  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      id_q        <= 1'b0;
      undef_q     <= 1'b0;
      setflag_q   <= 1'b0;
      alu_src_a   <= '0;
      alu_src_b   <= '0;
      alu_control <= '0;
      rsp_id      <= 1'b0;
      rsp_result  <= '0;
      rsp_flag    <= 1'b0;
      z_flag      <= 1'b0;
      ops_done    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid[grant]) begin
            alu_src_a   <= sel_a;
            alu_src_b   <= sel_b;
            // The undefined code never reaches the ALU; a harmless add is presented instead.
            alu_control <= (sel_op == 3'b111) ? 3'b000 : sel_op;
            undef_q     <= (sel_op == 3'b111);
            setflag_q   <= sel_op[2] || (sel_op == 3'b011);
            id_q        <= grant;
            last_grant  <= grant;
            state       <= EXEC;
          end
        end
        EXEC: begin
          rsp_id <= id_q;
          if (undef_q) begin
            rsp_result <= '0;
            z_flag     <= 1'b1;
            rsp_flag   <= 1'b1;
          end else begin
            rsp_result <= alu_result;
            if (setflag_q) begin
              z_flag   <= alu_flags;
              rsp_flag <= alu_flags;
            end else begin
              rsp_flag <= z_flag;
            end
          end
          state <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            ops_done <= ops_done + CNT_W'(1);
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: scenario tasks plus randomized traffic against a transaction-level model.
module tb_alu_arbiter;

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic [2:0]    req0_op, req1_op;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_flag;
  logic [W-1:0]  rsp_result;
  logic [W-1:0]  alu_src_a, alu_src_b, alu_result;
  logic [2:0]    alu_control;
  logic          alu_flags, z_flag;
  logic [CW-1:0] ops_done;

  int checks = 0;
  int errors = 0;

  // model state
  logic        m_z;
  int unsigned m_ops;
  int unsigned m_last;

  alu_arbiter #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_op(req0_op), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flag(rsp_flag),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .z_flag(z_flag), .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  // Stand-in for the shared ALU.
  always_comb begin
    case (alu_control)
      3'b000, 3'b100:         alu_result = alu_src_a + alu_src_b;
      3'b001, 3'b101, 3'b011: alu_result = alu_src_a - alu_src_b;
      3'b010, 3'b110:         alu_result = alu_src_b;
      default:                alu_result = '0;
    endcase
    alu_flags = (alu_result == '0);
  end

  function automatic logic [W-1:0] ref_res(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    if (op == 3'd7) return '0;
    if (op == 3'd0 || op == 3'd4) return a + b;
    if (op == 3'd2 || op == 3'd6) return b;
    return a - b;
  endfunction

  function automatic bit sets_flag(input logic [2:0] op);
    return (op == 3'd3 || op == 3'd4 || op == 3'd5 || op == 3'd6);
  endfunction

  task automatic set_req(input int unsigned p, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    if (p == 0) begin req0_a = a; req0_b = b; req0_op = op; end
    else        begin req1_a = a; req1_b = b; req1_op = op; end
    req_valid[p] = 1'b1;
  endtask

  task automatic rand_req(input int unsigned p);
    logic [W-1:0] a, b;
    a = $urandom;
    b = ($urandom_range(0, 3) == 0) ? a : $urandom;
    set_req(p, a, b, 3'($urandom_range(0, 7)));
  endtask

  // Runs one full transaction from the current IDLE state, checking every phase.
  task automatic serve(input int unsigned hold, input bit keep);
    int unsigned  n, g;
    logic [1:0]   exp_rdy;
    logic [W-1:0] a, b, er;
    logic [2:0]   op;
    #1;
    n = 0;
    while (req_ready == 2'b00 && n < 20) begin @(posedge clk); #1; n++; end
    g = (req_valid == 2'b11) ? ((m_last == 0) ? 1 : 0) : (req_valid[1] ? 1 : 0);
    exp_rdy = 2'b01 << g;
    checks++;
    if (req_ready !== exp_rdy) begin
      errors++;
      $display("FAIL grant req_ready=%b expected=%b", req_ready, exp_rdy);
      return;
    end
    a  = g[0] ? req1_a  : req0_a;
    b  = g[0] ? req1_b  : req0_b;
    op = g[0] ? req1_op : req0_op;
    @(posedge clk); #1;
    m_last = g;
    if (keep) rand_req(g); else req_valid[g] = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 2'b00) begin
      errors++;
      $display("FAIL exec_phase rsp_valid=%b req_ready=%b expected 0/00", rsp_valid, req_ready);
    end
    checks++;
    if (op == 3'd7) begin
      if (alu_control === 3'b111) begin
        errors++;
        $display("FAIL undef_to_alu alu_control=%b expected not 111", alu_control);
      end
    end else if ({alu_control, alu_src_a, alu_src_b} !== {op, a, b}) begin
      errors++;
      $display("FAIL alu_drive ctl=%b a=%h b=%h expected ctl=%b a=%h b=%h", alu_control, alu_src_a, alu_src_b, op, a, b);
    end
    er = ref_res(op, a, b);
    if (op == 3'd7) m_z = 1'b1;
    else if (sets_flag(op)) m_z = (er == '0);
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== g[0] || rsp_result !== er || rsp_flag !== m_z || z_flag !== m_z) begin
      errors++;
      $display("FAIL response valid=%b id=%b res=%h flag=%b z=%b expected 1 id=%0d res=%h flag=%b z=%b",
               rsp_valid, rsp_id, rsp_result, rsp_flag, z_flag, g, er, m_z, m_z);
    end
    for (int i = 0; i < int'(hold); i++) begin
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== er || rsp_id !== g[0] || req_ready !== 2'b00) begin
        errors++;
        $display("FAIL backpressure valid=%b res=%h id=%b ready=%b expected 1 %h %0d 00",
                 rsp_valid, rsp_result, rsp_id, req_ready, er, g);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    m_ops = (m_ops + 1) % (1 << CW);
    checks++;
    if (rsp_valid !== 1'b0 || ops_done !== m_ops[CW-1:0]) begin
      errors++;
      $display("FAIL completion rsp_valid=%b ops_done=%0d expected 0 %0d", rsp_valid, ops_done, m_ops);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #1;
    checks++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_flag, z_flag, ops_done, alu_src_a, alu_src_b, alu_control, req_ready} !== '0) begin
      errors++;
      $display("FAIL reset_values valid=%b id=%b res=%h flag=%b z=%b ops=%0d a=%h b=%h ctl=%b rdy=%b expected all 0",
               rsp_valid, rsp_id, rsp_result, rsp_flag, z_flag, ops_done, alu_src_a, alu_src_b, alu_control, req_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || ops_done !== '0 || req_ready !== 2'b00) begin
      errors++;
      $display("FAIL reset_hold valid=%b ops=%0d rdy=%b expected 0 0 00", rsp_valid, ops_done, req_ready);
    end
    req_valid = 2'b00;
    @(negedge clk);
    reset  = 1'b0;
    m_z    = 1'b0;
    m_ops  = 0;
    m_last = 1;
  endtask

  task automatic test_single_op;
    set_req(0, 32'd5, 32'd3, 3'b000);
    serve(0, 1'b0);
  endtask

  task automatic test_flag;
    set_req(1, 32'd7, 32'd7, 3'b101);
    serve(0, 1'b0);
    set_req(1, 32'd1, 32'd2, 3'b000);
    serve(0, 1'b0);
  endtask

  task automatic test_undef;
    set_req(0, 32'h1234, 32'h5678, 3'b111);
    serve(1, 1'b0);
  endtask

  task automatic test_backpressure;
    set_req(0, 32'h10, 32'h20, 3'b101);
    set_req(1, 32'h30, 32'h30, 3'b011);
    serve(5, 1'b0);
    serve(0, 1'b0);
  endtask

  task automatic test_round_robin;
    rand_req(0);
    rand_req(1);
    repeat (4) serve(0, 1'b1);
    req_valid = 2'b00;
  endtask

  task automatic test_reset_mid;
    set_req(0, 32'd9, 32'd9, 3'b101);
    #1;
    @(posedge clk); #1;
    test_reset();
    set_req(1, 32'd4, 32'd4, 3'b101);
    #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL reach_resp rsp_valid=%b expected 1", rsp_valid);
    end
    test_reset();
    rand_req(0);
    rand_req(1);
    serve(0, 1'b0);
    serve(0, 1'b0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++) begin
      for (int p = 0; p < 2; p++)
        if (!req_valid[p] && $urandom_range(0, 1) == 1) rand_req(p);
      if (req_valid == 2'b00) rand_req($urandom_range(0, 1));
      serve($urandom_range(0, 2), ($urandom_range(0, 1) == 1));
    end
    req_valid = 2'b00;
  endtask

  initial begin
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    req0_a = '0; req0_b = '0; req0_op = '0;
    req1_a = '0; req1_b = '0; req1_op = '0;
    test_reset();
    test_single_op();
    test_flag();
    test_undef();
    test_backpressure();
    test_round_robin();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
